// File: rtl/encryptor_job_scheduler.sv
// Round-robin scheduler that shares one memory-mapped encryptor between two job requesters.
// Runs the key/plaintext/go/poll/readback sequence per job and returns the cyphertext.
module encryptor_job_scheduler #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rq0_valid,
  output logic         rq0_ready,
  input  logic [127:0] rq0_key,
  input  logic [127:0] rq0_pt,
  input  logic         rq1_valid,
  output logic         rq1_ready,
  input  logic [127:0] rq1_key,
  input  logic [127:0] rq1_pt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [31:0]  acc_addr,
  output logic         acc_wr_en,
  output logic         acc_select,
  output logic [31:0]  acc_wdata,
  input  logic [31:0]  acc_rdata,
  output logic         busy
);

  // state  | meaning
  // IDLE   | arbitrate between requesters, latch the granted job
  // WR_KEY | write key words 0..3
  // WR_PT  | write plaintext words 0..3
  // GO     | write go bit to control register
  // WAIT   | settle cycle while the accelerator clears done
  // POLL   | sample done, abort after TIMEOUT cycles
  // RD_CT  | read cyphertext words 0..3
  // RESP   | present result until accepted
  typedef enum logic [2:0] {
    S_IDLE, S_WR_KEY, S_WR_PT, S_GO, S_WAIT, S_POLL, S_RD_CT, S_RESP
  } state_t;

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            id_q, id_d;
  logic            err_q, err_d;
  logic [1:0]      idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    pt_q, pt_d;
  logic [127:0]    data_q, data_d;
  logic            grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= 2'd0;
      timer_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    err_d      = err_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    key_d      = key_q;
    pt_d       = pt_q;
    data_d     = data_q;
    rq0_ready  = 1'b0;
    rq1_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    acc_addr   = '0;
    acc_wr_en  = 1'b0;
    acc_select = 1'b0;
    acc_wdata  = '0;
    // requester 1 wins when alone, or when both are valid and 0 went last
    grant      = rq1_valid & (~rq0_valid | ~last_q);

    case (state_q)
      S_IDLE: begin
        // ready is gated by reset so every output reads 0 while rst is high
        if (!rst && (rq0_valid || rq1_valid)) begin
          rq0_ready = ~grant;
          rq1_ready = grant;
          key_d     = grant ? rq1_key : rq0_key;
          pt_d      = grant ? rq1_pt : rq0_pt;
          id_d      = grant;
          last_d    = grant;
          idx_d     = 2'd0;
          timer_d   = '0;
          data_d    = '0;
          err_d     = 1'b0;
          state_d   = S_WR_KEY;
        end
      end
      S_WR_KEY: begin
        acc_addr   = BASE_ADDR + 32'h28 + {28'd0, idx_q, 2'b00};
        acc_wr_en  = 1'b1;
        acc_select = 1'b1;
        acc_wdata  = key_q[{idx_q, 5'd0} +: 32];
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_WR_PT;
      end
      S_WR_PT: begin
        acc_addr   = BASE_ADDR + 32'h38 + {28'd0, idx_q, 2'b00};
        acc_wr_en  = 1'b1;
        acc_select = 1'b1;
        acc_wdata  = pt_q[{idx_q, 5'd0} +: 32];
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_GO;
      end
      S_GO: begin
        acc_addr   = BASE_ADDR + 32'h20;
        acc_wr_en  = 1'b1;
        acc_select = 1'b1;
        acc_wdata  = 32'h1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        acc_addr   = BASE_ADDR + 32'h20;
        acc_select = 1'b1;
        state_d    = S_POLL;
      end
      S_POLL: begin
        acc_addr   = BASE_ADDR + 32'h20;
        acc_select = 1'b1;
        if (acc_rdata[31]) begin
          state_d = S_RD_CT;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RD_CT: begin
        acc_addr   = BASE_ADDR + 32'h48 + {28'd0, idx_q, 2'b00};
        acc_select = 1'b1;
        data_d[{idx_q, 5'd0} +: 32] = acc_rdata;
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = data_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_encryptor_job_scheduler.sv
// Randomised scoreboard bench for encryptor_job_scheduler with a behavioural accelerator model.
module tb_encryptor_job_scheduler;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TO   = 8;
  localparam int          NEVER = 1000;

  typedef struct {logic [127:0] key; logic [127:0] pt; int d;} job_t;
  typedef struct {logic id; logic [127:0] data; logic err; int cyc;} exp_t;
  typedef struct {logic we; logic chk_wd; logic [31:0] addr; logic [31:0] wd;} bus_t;

  logic clk = 1'b0;
  logic rst;
  logic rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [127:0] rq0_key, rq0_pt, rq1_key, rq1_pt;
  logic rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic [31:0] acc_addr, acc_wdata, acc_rdata;
  logic acc_wr_en, acc_select, busy;

  encryptor_job_scheduler #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_key(rq0_key), .rq0_pt(rq0_pt),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_key(rq1_key), .rq1_pt(rq1_pt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_select(acc_select),
    .acc_wdata(acc_wdata), .acc_rdata(acc_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] outs();
    return {56'd0, rq0_ready, rq1_ready, rsp_valid, rsp_id, rsp_err, busy, acc_wr_en,
            acc_select, acc_addr, acc_wdata, rsp_data};
  endfunction

  // Reference transform the accelerator applies; the bench predicts results with it.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] c;
    logic [31:0] w;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      w = k[i*32 +: 32] ^ p[((i + 1) % 4)*32 +: 32];
      w = (w << (3 + 5*i)) | (w >> (29 - 5*i));
      c[i*32 +: 32] = w + 32'h9E37_79B9 + 32'(i);
    end
    return c;
  endfunction

  function automatic job_t mkjob(input int d);
    job_t j;
    j.key = {$urandom, $urandom, $urandom, $urandom};
    j.pt  = {$urandom, $urandom, $urandom, $urandom};
    j.d   = d;
    return j;
  endfunction

  job_t q0[$], q1[$];
  job_t cur0, cur1;
  exp_t sb[$];
  bus_t bq[$];
  int   dq[$];
  int   grant_log[$];
  logic acc0 = 1'b0, acc1 = 1'b0;
  logic model_last = 1'b1;
  int   bp_mode = 0;

  // accelerator model: registers written by the DUT, done after d cycles from go
  logic [127:0] m_key = '0, m_pt = '0;
  logic [127:0] m_ct;
  int   m_cnt = 0, m_d = NEVER;
  logic m_arm = 1'b0;
  logic m_done;
  assign m_ct   = cipher(m_key, m_pt);
  assign m_done = m_arm && (m_cnt >= m_d);

  always_comb begin
    acc_rdata = 32'h0;
    if (acc_addr == BASE + 32'h20) acc_rdata = {m_done, 31'h0};
    for (int i = 0; i < 4; i++)
      if (acc_addr == BASE + 32'h48 + 32'(4*i)) acc_rdata = m_ct[i*32 +: 32];
  end

  always @(posedge clk) begin
    if (acc_select && acc_wr_en && acc_addr == BASE + 32'h20 && acc_wdata[0]) begin
      m_arm <= 1'b1;
      m_cnt <= 0;
      if (dq.size() > 0) m_d <= dq.pop_front();
      else m_d <= NEVER;
    end else if (m_cnt < 100000) begin
      m_cnt <= m_cnt + 1;
    end
    if (acc_select && acc_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_addr == BASE + 32'h28 + 32'(4*i)) m_key[i*32 +: 32] <= acc_wdata;
        if (acc_addr == BASE + 32'h38 + 32'(4*i)) m_pt[i*32 +: 32] <= acc_wdata;
      end
    end
  end

  // requester drivers: hold valid until accepted, then present the next queued job
  initial begin
    rq0_valid = 1'b0; rq0_key = '0; rq0_pt = '0;
    forever begin
      @(posedge clk); #1;
      if (acc0) rq0_valid = 1'b0;
      if (!rq0_valid && q0.size() > 0) begin
        cur0 = q0.pop_front();
        rq0_key = cur0.key; rq0_pt = cur0.pt; rq0_valid = 1'b1;
      end
    end
  end

  initial begin
    rq1_valid = 1'b0; rq1_key = '0; rq1_pt = '0;
    forever begin
      @(posedge clk); #1;
      if (acc1) rq1_valid = 1'b0;
      if (!rq1_valid && q1.size() > 0) begin
        cur1 = q1.pop_front();
        rq1_key = cur1.key; rq1_pt = cur1.pt; rq1_valid = 1'b1;
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // monitor: bus sequence, arbitration and response checks
  exp_t m_e;
  bus_t m_b;
  job_t m_j;
  logic m_id, m_err, in_rsp = 1'b0;
  int   m_polls;
  logic [1:0] m_expv;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete(); bq.delete(); dq.delete(); grant_log.delete();
      in_rsp = 1'b0; model_last = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      if (bq.size() > 0) begin
        m_b = bq.pop_front();
        chk("bus", {acc_select, acc_wr_en, acc_addr, m_b.chk_wd ? acc_wdata : 32'h0},
            {1'b1, m_b.we, m_b.addr, m_b.chk_wd ? m_b.wd : 32'h0});
      end else begin
        chk("bus_quiet", {acc_select, acc_wr_en, acc_addr, acc_wdata}, '0);
      end

      if (in_rsp) begin
        chk("rsp_hold_valid", rsp_valid, 1'b1);
        chk("rsp_stable", {rsp_id, rsp_err, rsp_data}, {m_e.id, m_e.err, m_e.data});
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          m_e = sb[0];
          chk("rsp_id", rsp_id, m_e.id);
          chk("rsp_err", rsp_err, m_e.err);
          chk("rsp_data", rsp_data, m_e.data);
          chk("rsp_latency", cyc, m_e.cyc);
        end
        in_rsp = 1'b1;
      end
      if (rsp_valid) chk("rsp_busy", busy, 1'b1);
      if (in_rsp && rsp_valid && rsp_ready) begin
        in_rsp = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end

      chk("ready_only_valid", {rq1_ready & ~rq1_valid, rq0_ready & ~rq0_valid}, '0);
      if (!busy) begin
        if (rq0_valid && rq1_valid) m_expv = model_last ? 2'b01 : 2'b10;
        else if (rq0_valid)         m_expv = 2'b01;
        else if (rq1_valid)         m_expv = 2'b10;
        else                        m_expv = 2'b00;
        chk("grant", {rq1_ready, rq0_ready}, m_expv);
      end else begin
        chk("ready_while_busy", {rq1_ready, rq0_ready}, '0);
      end

      acc0 = rq0_valid && rq0_ready;
      acc1 = rq1_valid && rq1_ready;
      if (acc0 || acc1) begin
        m_id = acc1;
        m_j  = m_id ? cur1 : cur0;
        model_last = m_id;
        grant_log.push_back(int'(m_id));
        m_err   = (m_j.d > TO);
        m_polls = m_err ? TO : m_j.d;
        sb.push_back('{id: m_id, data: m_err ? 128'h0 : cipher(m_j.key, m_j.pt),
                       err: m_err, cyc: cyc + 11 + m_polls + (m_err ? 0 : 4)});
        for (int i = 0; i < 4; i++)
          bq.push_back('{we: 1'b1, chk_wd: 1'b1, addr: BASE + 32'h28 + 32'(4*i), wd: m_j.key[i*32 +: 32]});
        for (int i = 0; i < 4; i++)
          bq.push_back('{we: 1'b1, chk_wd: 1'b1, addr: BASE + 32'h38 + 32'(4*i), wd: m_j.pt[i*32 +: 32]});
        bq.push_back('{we: 1'b1, chk_wd: 1'b1, addr: BASE + 32'h20, wd: 32'h1});
        for (int i = 0; i < m_polls + 1; i++)
          bq.push_back('{we: 1'b0, chk_wd: 1'b0, addr: BASE + 32'h20, wd: 32'h0});
        if (!m_err)
          for (int i = 0; i < 4; i++)
            bq.push_back('{we: 1'b0, chk_wd: 1'b0, addr: BASE + 32'h48 + 32'(4*i), wd: 32'h0});
        dq.push_back(m_j.d);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !rq0_valid && !rq1_valid &&
             sb.size() == 0 && !busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_idle: no idle within %0d cycles", budget);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_cond_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_poll(input int budget);
    int n = 0;
    while (!(acc_select && !acc_wr_en && acc_addr == BASE + 32'h20) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL wait_poll: no poll cycle within %0d cycles", budget);
    end
  endtask

  initial begin
    job_t j;
    int   d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", outs(), '0);
    rst = 1'b0;

    // single job from requester 0, done three cycles after go
    j.key = {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201};
    j.pt  = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h11223344};
    j.d   = 3;
    q0.push_back(j);
    wait_idle(200);

    // both requesters valid out of reset: expect grants 0,1,0
    @(posedge clk); #2;
    rst = 1'b1;
    q0.push_back(mkjob(int'($urandom_range(1, TO))));
    q0.push_back(mkjob(int'($urandom_range(1, TO))));
    q1.push_back(mkjob(int'($urandom_range(1, TO))));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_idle(400);
    chk("grant_count", grant_log.size(), 3);
    if (grant_log.size() == 3)
      chk("grant_order", {grant_log[0][0], grant_log[1][0], grant_log[2][0]}, 3'b010);

    // timeout, then done on exactly the last allowed poll, then one past it
    q0.push_back(mkjob(NEVER));
    wait_idle(200);
    q1.push_back(mkjob(TO));
    q0.push_back(mkjob(TO + 1));
    q0.push_back(mkjob(1));
    wait_idle(400);

    // response back-pressure with a competing request pending
    bp_mode = 2;
    q0.push_back(mkjob(2));
    wait_cond_rsp(100);
    q1.push_back(mkjob(3));
    repeat (5) @(posedge clk);
    bp_mode = 0;
    wait_idle(200);

    // reset during POLL drops the job; a pending request is served afterwards
    q0.push_back(mkjob(NEVER));
    q0.push_back(mkjob(2));
    wait_poll(100);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", outs(), '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_idle(200);

    // randomised traffic with random back-pressure
    bp_mode = 1;
    for (int n = 0; n < 30; n++) begin
      d = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, TO + 1));
      if ($urandom_range(0, 1) == 1) q0.push_back(mkjob(d));
      else q1.push_back(mkjob(d));
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    wait_idle(3000);
    bp_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
